// File: rtl/stream_reduce.sv
// Column-reduction core: SUM/MIN/MAX/COUNT over ilast-framed groups of signed elements.
// Optional saturating SUM/COUNT with a sticky osat flag under STREAM_REDUCE_SAT_EN.
module stream_reduce #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] idata,
  input  logic                ivalid,
  input  logic                ilast,
  output logic                istop,
  input  logic        [1:0]   op,
  output logic signed [W-1:0] odata,
  output logic                ovalid,
  input  logic                ostop,
  output logic                osat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_MIN = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;
  localparam logic [1:0] OP_CNT = 2'b11;

  localparam logic signed [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [1:0]          op_q;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] acc_next;
  logic                accept;

`ifdef STREAM_REDUCE_SAT_EN
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum_ext;
  logic       ovf;
  logic       sat_flag;
`endif

  assign accept = ivalid && !istop;
  assign istop  = (state == EMIT);
  assign ovalid = (state == EMIT);
  assign odata  = ovalid ? acc : '0;

`ifdef STREAM_REDUCE_SAT_EN
  assign osat = ovalid && sat_flag;
`else
  assign osat = 1'b0;
`endif

  always_comb begin
    acc_next = acc;
`ifdef STREAM_REDUCE_SAT_EN
    ovf     = 1'b0;
    // One guard bit: overflow iff the two top bits of the widened sum disagree.
    sum_ext = {acc[W-1], acc} + {idata[W-1], idata};
`endif
    case (op_q)
      OP_SUM: begin
`ifdef STREAM_REDUCE_SAT_EN
        if (sum_ext[W] != sum_ext[W-1]) begin
          ovf      = 1'b1;
          acc_next = sum_ext[W] ? SMIN : SMAX;
        end else begin
          acc_next = sum_ext[W-1:0];
        end
`else
        acc_next = acc + idata;
`endif
      end
      OP_MIN: if (idata < acc) acc_next = idata;
      OP_MAX: if (idata > acc) acc_next = idata;
      OP_CNT: begin
`ifdef STREAM_REDUCE_SAT_EN
        if (acc == SMAX) ovf = 1'b1;
        else             acc_next = acc + ONE;
`else
        acc_next = acc + ONE;
`endif
      end
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_SUM;
      acc   <= '0;
`ifdef STREAM_REDUCE_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            acc   <= (op == OP_CNT) ? ONE : idata;
            state <= ilast ? EMIT : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
`ifdef STREAM_REDUCE_SAT_EN
            sat_flag <= sat_flag | ovf;
`endif
            if (ilast) state <= EMIT;
          end
        end
        EMIT: begin
          if (!ostop) begin
            state <= IDLE;
`ifdef STREAM_REDUCE_SAT_EN
            sat_flag <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
